// File: rtl/sc_reg_shifter_pkg.sv
// Shared encodings for the row register/shifter: command modes and FSM states.
package sc_reg_shifter_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // True for the four multi-step commands; 3'b111 is an alias of hold.
  function automatic logic isShiftMode(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/sc_reg_shifter_step.sv
// Single shift/rotate step: computes the next register value and the bit pushed out.
module sc_reg_shifter_step
  import sc_reg_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] curReg,
  input  logic [2:0]       mode,
  input  logic             serialIn,
  output logic [WIDTH-1:0] nextReg,
  output logic             expelledBit
);

  // Shifts take the external fill bit; rotates recycle the expelled bit.
  always_comb begin
    nextReg     = curReg;
    expelledBit = 1'b0;
    case (mode)
      MODE_SHL: begin
        nextReg     = {curReg[WIDTH-2:0], serialIn};
        expelledBit = curReg[WIDTH-1];
      end
      MODE_SHR: begin
        nextReg     = {serialIn, curReg[WIDTH-1:1]};
        expelledBit = curReg[0];
      end
      MODE_ROL: begin
        nextReg     = {curReg[WIDTH-2:0], curReg[WIDTH-1]};
        expelledBit = curReg[WIDTH-1];
      end
      MODE_ROR: begin
        nextReg     = {curReg[0], curReg[WIDTH-1:1]};
        expelledBit = curReg[0];
      end
      default: begin
        nextReg     = curReg;
        expelledBit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sc_reg_shifter.sv
// Row register with load/clear and multi-step shift/rotate under a start/busy/done handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready; start accepted, single-cycle commands finish here
// ST_SHIFT | one step per edge, step counter counts down to 1
// ST_DONE  | done pulse for one cycle, busy still high, then back to idle
module sc_reg_shifter
  import sc_reg_shifter_pkg::*;
#(
  parameter int                              SC_REG_SHIFTER_WIDTH       = 8,
  parameter int                              SC_REG_SHIFTER_CNT_WIDTH   = 4,
  parameter logic [SC_REG_SHIFTER_WIDTH-1:0] SC_REG_SHIFTER_RESET_VALUE = '0
) (
  input  logic                                SC_REG_SHIFTER_CLOCK_50,
  input  logic                                SC_REG_SHIFTER_RESET_InHigh,
  input  logic [SC_REG_SHIFTER_WIDTH-1:0]     SC_REG_SHIFTER_data_InBUS,
  input  logic [2:0]                          SC_REG_SHIFTER_mode_InBUS,
  input  logic [SC_REG_SHIFTER_CNT_WIDTH-1:0] SC_REG_SHIFTER_steps_InBUS,
  input  logic                                SC_REG_SHIFTER_serial_In,
  input  logic                                SC_REG_SHIFTER_start_In,
  output logic [SC_REG_SHIFTER_WIDTH-1:0]     SC_REG_SHIFTER_data_OutBUS,
  output logic                                SC_REG_SHIFTER_serial_Out,
  output logic                                SC_REG_SHIFTER_busy_Out,
  output logic                                SC_REG_SHIFTER_done_Out
);

  localparam int W  = SC_REG_SHIFTER_WIDTH;
  localparam int CW = SC_REG_SHIFTER_CNT_WIDTH;

  state_e          stateQ;
  logic [2:0]      shiftModeQ;
  logic [CW-1:0]   stepCntQ;
  logic [W-1:0]    regQ;
  logic            serialQ;
  logic            busyQ;
  logic            doneQ;
  logic [W-1:0]    stepNext;
  logic            stepExpelled;

  sc_reg_shifter_step #(
    .WIDTH(W)
  ) stepUnit (
    .curReg     (regQ),
    .mode       (shiftModeQ),
    .serialIn   (SC_REG_SHIFTER_serial_In),
    .nextReg    (stepNext),
    .expelledBit(stepExpelled)
  );

  // Command FSM: register bank, step down-counter and registered handshake outputs.
  always_ff @(posedge SC_REG_SHIFTER_CLOCK_50) begin
    if (SC_REG_SHIFTER_RESET_InHigh) begin
      stateQ     <= ST_IDLE;
      shiftModeQ <= MODE_HOLD;
      stepCntQ   <= '0;
      regQ       <= SC_REG_SHIFTER_RESET_VALUE;
      serialQ    <= 1'b0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      case (stateQ)
        ST_IDLE: begin
          busyQ <= 1'b0;
          doneQ <= 1'b0;
          if (SC_REG_SHIFTER_start_In) begin
            if (isShiftMode(SC_REG_SHIFTER_mode_InBUS) &&
                (SC_REG_SHIFTER_steps_InBUS != '0)) begin
              // First step happens on the following edge.
              shiftModeQ <= SC_REG_SHIFTER_mode_InBUS;
              stepCntQ   <= SC_REG_SHIFTER_steps_InBUS;
              stateQ     <= ST_SHIFT;
              busyQ      <= 1'b1;
            end else begin
              if (SC_REG_SHIFTER_mode_InBUS == MODE_LOAD) begin
                regQ <= SC_REG_SHIFTER_data_InBUS;
              end else if (SC_REG_SHIFTER_mode_InBUS == MODE_CLR) begin
                regQ <= '0;
              end
              stateQ <= ST_DONE;
              busyQ  <= 1'b1;
              doneQ  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          regQ     <= stepNext;
          serialQ  <= stepExpelled;
          stepCntQ <= stepCntQ - CW'(1);
          busyQ    <= 1'b1;
          if (stepCntQ == CW'(1)) begin
            stateQ <= ST_DONE;
            doneQ  <= 1'b1;
          end
        end
        ST_DONE: begin
          stateQ <= ST_IDLE;
          busyQ  <= 1'b0;
          doneQ  <= 1'b0;
        end
        default: begin
          stateQ <= ST_IDLE;
          busyQ  <= 1'b0;
          doneQ  <= 1'b0;
        end
      endcase
    end
  end

  assign SC_REG_SHIFTER_data_OutBUS = regQ;
  assign SC_REG_SHIFTER_serial_Out  = serialQ;
  assign SC_REG_SHIFTER_busy_Out    = busyQ;
  assign SC_REG_SHIFTER_done_Out    = doneQ;

endmodule

// File: tb/tb_sc_reg_shifter.sv
// Directed and randomized checks of sc_reg_shifter against an arithmetic reference model.
module tb_sc_reg_shifter;
  import sc_reg_shifter_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  dataIn;
  logic [2:0]    mode;
  logic [CW-1:0] steps;
  logic          serialIn;
  logic          start;
  logic [W-1:0]  dataOut;
  logic          serialOut;
  logic          busy;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;
  int mr          = 0;
  bit ms          = 1'b0;

  always #5 clk = ~clk;

  sc_reg_shifter #(
    .SC_REG_SHIFTER_WIDTH      (W),
    .SC_REG_SHIFTER_CNT_WIDTH  (CW),
    .SC_REG_SHIFTER_RESET_VALUE(8'h00)
  ) dut (
    .SC_REG_SHIFTER_CLOCK_50    (clk),
    .SC_REG_SHIFTER_RESET_InHigh(rst),
    .SC_REG_SHIFTER_data_InBUS  (dataIn),
    .SC_REG_SHIFTER_mode_InBUS  (mode),
    .SC_REG_SHIFTER_steps_InBUS (steps),
    .SC_REG_SHIFTER_serial_In   (serialIn),
    .SC_REG_SHIFTER_start_In    (start),
    .SC_REG_SHIFTER_data_OutBUS (dataOut),
    .SC_REG_SHIFTER_serial_Out  (serialOut),
    .SC_REG_SHIFTER_busy_Out    (busy),
    .SC_REG_SHIFTER_done_Out    (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int expData, input bit expSer,
                          input bit expBusy, input bit expDone);
    check({tag, "_data"},   32'(dataOut),   32'(expData));
    check({tag, "_serial"}, 32'(serialOut), 32'(expSer));
    check({tag, "_busy"},   32'(busy),      32'(expBusy));
    check({tag, "_done"},   32'(done),      32'(expDone));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference step in plain integer arithmetic on the 8-bit row value.
  function automatic void modelStep(input logic [2:0] m, input bit fill);
    int ex;
    case (m)
      MODE_SHL: begin ex = mr / 128; mr = (mr * 2) % 256 + int'(fill);       ms = bit'(ex); end
      MODE_SHR: begin ex = mr % 2;   mr = mr / 2 + int'(fill) * 128;         ms = bit'(ex); end
      MODE_ROL: begin ex = mr / 128; mr = (mr * 2) % 256 + ex;               ms = bit'(ex); end
      MODE_ROR: begin ex = mr % 2;   mr = mr / 2 + ex * 128;                 ms = bit'(ex); end
      default: ;
    endcase
  endfunction

  // Issue one command from idle and follow it cycle by cycle until idle again.
  task automatic runCmd(input logic [2:0] m, input int k, input int d, input bit fill,
                        input bit randFill, input bit noise);
    bit f;
    mode     = m;
    steps    = CW'(k);
    dataIn   = W'(d);
    start    = 1'b1;
    f        = randFill ? bit'($urandom_range(0, 1)) : fill;
    serialIn = f;
    tick();
    start = 1'b0;
    if (!(m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR}) || k == 0) begin
      if (m == MODE_LOAD) mr = d % 256;
      else if (m == MODE_CLR) mr = 0;
      checkAll("cmd_e0", mr, ms, 1'b1, 1'b1);
      tick();
      checkAll("cmd_e1", mr, ms, 1'b0, 1'b0);
    end else begin
      checkAll("shift_e0", mr, ms, 1'b1, 1'b0);
      for (int i = 1; i <= k; i++) begin
        f        = randFill ? bit'($urandom_range(0, 1)) : fill;
        serialIn = f;
        if (noise) begin
          start  = 1'b1;
          mode   = (i == 1) ? 3'(MODE_LOAD) : 3'($urandom_range(0, 7));
          dataIn = (i == 1) ? 8'h55 : W'($urandom);
          steps  = CW'($urandom);
        end
        tick();
        modelStep(m, f);
        checkAll("shift_step", mr, ms, 1'b1, i == k);
      end
      start = 1'b0;
      tick();
      checkAll("shift_end", mr, ms, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 3'b000;
    steps    = '0;
    dataIn   = '0;
    serialIn = 1'b0;

    // Reset state
    tick();
    tick();
    checkAll("reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset then load
    runCmd(MODE_LOAD, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("load_a5", 32'(dataOut), 32'h0000_00A5);

    // Reset wins over a simultaneous start
    rst    = 1'b1;
    start  = 1'b1;
    mode   = MODE_LOAD;
    dataIn = 8'hFF;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    mr    = 0;
    ms    = 1'b0;
    checkAll("reset2", 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkAll("reset2_idle", 0, 1'b0, 1'b0, 1'b0);

    // Shift fill
    runCmd(MODE_LOAD, 0, 8'h81, 1'b0, 1'b0, 1'b0);
    runCmd(MODE_SHL, 3, 0, 1'b1, 1'b0, 1'b0);
    check("fill_final", 32'(dataOut), 32'h0000_000F);

    // Rotates
    runCmd(MODE_LOAD, 0, 8'h81, 1'b0, 1'b0, 1'b0);
    runCmd(MODE_ROR, 1, 0, 1'b0, 1'b0, 1'b0);
    check("ror1_data", 32'(dataOut), 32'h0000_00C0);
    check("ror1_serial", 32'(serialOut), 32'h1);
    runCmd(MODE_LOAD, 0, 8'h81, 1'b0, 1'b0, 1'b0);
    runCmd(MODE_ROL, 8, 0, 1'b1, 1'b0, 1'b0);
    check("rol8_data", 32'(dataOut), 32'h0000_0081);

    // Boundaries: zero steps, maximum steps
    runCmd(MODE_SHR, 0, 0, 1'b1, 1'b0, 1'b0);
    runCmd(MODE_CLR, 0, 0, 1'b0, 1'b0, 1'b0);
    runCmd(3'b111, 0, 8'h12, 1'b0, 1'b0, 1'b0);
    runCmd(MODE_LOAD, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    runCmd(MODE_SHL, 15, 0, 1'b0, 1'b0, 1'b0);
    check("shl15_data", 32'(dataOut), 32'h0);

    // Start while busy is ignored
    runCmd(MODE_LOAD, 0, 8'h3C, 1'b0, 1'b0, 1'b0);
    runCmd(MODE_SHL, 4, 0, 1'b1, 1'b0, 1'b1);
    check("ignored_data", 32'(dataOut), 32'h0000_00CF);
    check("ignored_serial", 32'(serialOut), 32'h1);

    // Reset in the middle of a rotate
    runCmd(MODE_LOAD, 0, 8'h96, 1'b0, 1'b0, 1'b0);
    mode     = MODE_ROR;
    steps    = CW'(5);
    serialIn = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    modelStep(MODE_ROR, 1'b0);
    tick();
    modelStep(MODE_ROR, 1'b0);
    checkAll("midop_step2", mr, ms, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mr  = 0;
    ms  = 1'b0;
    checkAll("midreset", 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkAll("midreset_after", 0, 1'b0, 1'b0, 1'b0);
    runCmd(MODE_LOAD, 0, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Randomized commands, fill bits and busy-time noise
    repeat (60) begin
      runCmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
             1'b0, 1'b1, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
